regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file for the secure_soc CPU core. It is the next generation of the single-write/dual-read file.
//  - Adds configurable width, depth, and number of read and write ports.
//  - Adds write-to-read bypass.
//  - Adds a hardware zeroize sequence that erases register contents on a security event.
//  - Adds a registered debug read port with a req/ack handshake.

---
 rtl/rf_pkg.sv | 22 ++
 rtl/rf_zeroize_fsm.sv | 72 +++++++
 rtl/regfile_mp.sv | 118 +++++++++++
 tb/tb_regfile_mp.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rf_pkg : shared types and helpers for the multi-port register file
// Revision: 1.0
// ---------------------------------------------------------------------------
package rf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } zstate_e;

    localparam logic RF_ZERO = 1'b0;

    // Counter width that stays legal when only one bank exists.
    function automatic int cnt_width(input int nbank);
        return (nbank > 1) ? $clog2(nbank) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_zeroize_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rf_zeroize_fsm : sequences bank-by-bank erase of the register file
// Revision: 1.0
// ---------------------------------------------------------------------------
module rf_zeroize_fsm
    import rf_pkg::*;
#(
    parameter  int NBANK = 8,
    localparam int CW    = cnt_width(NBANK)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          zeroize_req_i,
    output logic [CW-1:0] clr_bank_o,
    output logic          clr_en_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam logic [CW-1:0] C_LAST = CW'(NBANK - 1);

    zstate_e       r_state;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (zeroize_req_i) begin
                        r_state <= CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (r_cnt == C_LAST) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Always return to IDLE so a held request cannot chain directly.
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_bank_o = r_cnt;
    assign clr_en_o   = (r_state == CLEAR);
    assign busy_o     = r_busy;
    assign done_o     = r_done;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_mp : parametrised multi-port register file with bypass, zeroize
//              and a latency-1 debug read port
// Revision: 1.0
// ---------------------------------------------------------------------------
module regfile_mp
    import rf_pkg::*;
#(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    parameter  int NRD  = 2,
    parameter  int NWR  = 1,
    parameter  int ZPC  = 4,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NWR-1:0]            we_i,
    input  logic [NWR-1:0][AW-1:0]    waddr_i,
    input  logic [NWR-1:0][XLEN-1:0]  wdata_i,
    input  logic [NRD-1:0][AW-1:0]    raddr_i,
    output logic [NRD-1:0][XLEN-1:0]  rdata_o,
    input  logic                      zeroize_req_i,
    output logic                      zeroize_busy_o,
    output logic                      zeroize_done_o,
    input  logic                      dbg_req_i,
    input  logic [AW-1:0]             dbg_addr_i,
    output logic                      dbg_ack_o,
    output logic [XLEN-1:0]           dbg_data_o
);

    localparam int NBANK = NREG / ZPC;
    localparam int CW    = cnt_width(NBANK);
    localparam logic [XLEN-1:0] C_ZERO = {XLEN{RF_ZERO}};

    logic [XLEN-1:0] r_regs [NREG];
    logic            r_dbg_ack;
    logic [XLEN-1:0] r_dbg_data;

    logic [CW-1:0]   w_clr_bank;
    logic            w_clr_en;
    logic            w_busy;
    logic            w_done;
    logic [AW-1:0]   w_clr_base;
    logic [NWR-1:0]  w_wvalid;

    rf_zeroize_fsm #(
        .NBANK (NBANK)
    ) u_zfsm (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .zeroize_req_i (zeroize_req_i),
        .clr_bank_o    (w_clr_bank),
        .clr_en_o      (w_clr_en),
        .busy_o        (w_busy),
        .done_o        (w_done)
    );

    assign w_clr_base = AW'(int'(w_clr_bank) * ZPC);

    for (genvar w = 0; w < NWR; w++) begin : g_wr
        assign w_wvalid[w] = we_i[w] && (waddr_i[w] != '0) && !w_busy;
    end

    // Ascending port order lets the higher-numbered port win on collisions.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= C_ZERO;
            end
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (w_wvalid[w]) begin
                    r_regs[waddr_i[w]] <= wdata_i[w];
                end
            end
            if (w_clr_en) begin
                for (int j = 0; j < ZPC; j++) begin
                    r_regs[w_clr_base + AW'(j)] <= C_ZERO;
                end
            end
        end
    end

    for (genvar r = 0; r < NRD; r++) begin : g_rd
        logic [XLEN-1:0] w_rd;
        always_comb begin
            w_rd = r_regs[raddr_i[r]];
            for (int w = 0; w < NWR; w++) begin
                if (w_wvalid[w] && (waddr_i[w] == raddr_i[r])) begin
                    w_rd = wdata_i[w];
                end
            end
            if (!rst_ni || w_busy || (raddr_i[r] == '0)) begin
                w_rd = C_ZERO;
            end
        end
        assign rdata_o[r] = w_rd;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_dbg_ack  <= 1'b0;
            r_dbg_data <= C_ZERO;
        end else begin
            r_dbg_ack  <= dbg_req_i;
            r_dbg_data <= (dbg_req_i && !w_busy) ? r_regs[dbg_addr_i] : C_ZERO;
        end
    end

    assign zeroize_busy_o = w_busy;
    assign zeroize_done_o = w_done;
    assign dbg_ack_o      = r_dbg_ack;
    assign dbg_data_o     = r_dbg_data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_regfile_mp : directed self-checking bench for regfile_mp (NWR=2)
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_regfile_mp;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic [1:0]       we_i;
    logic [1:0][4:0]  waddr_i;
    logic [1:0][31:0] wdata_i;
    logic [1:0][4:0]  raddr_i;
    logic [1:0][31:0] rdata_o;
    logic             zeroize_req_i;
    logic             zeroize_busy_o;
    logic             zeroize_done_o;
    logic             dbg_req_i;
    logic [4:0]       dbg_addr_i;
    logic             dbg_ack_o;
    logic [31:0]      dbg_data_o;

    int n_chk = 0;
    int n_err = 0;

    regfile_mp #(
        .XLEN (32), .NREG (32), .NRD (2), .NWR (2), .ZPC (4)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .we_i           (we_i),
        .waddr_i        (waddr_i),
        .wdata_i        (wdata_i),
        .raddr_i        (raddr_i),
        .rdata_o        (rdata_o),
        .zeroize_req_i  (zeroize_req_i),
        .zeroize_busy_o (zeroize_busy_o),
        .zeroize_done_o (zeroize_done_o),
        .dbg_req_i      (dbg_req_i),
        .dbg_addr_i     (dbg_addr_i),
        .dbg_ack_o      (dbg_ack_o),
        .dbg_data_o     (dbg_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd0(input logic [4:0] a, input logic [31:0] exp, input string tag);
        raddr_i[0] = a;
        #1;
        chk(tag, rdata_o[0], exp);
    endtask

    // x1..x31 = index, two registers per cycle.
    task automatic fill();
        for (int k = 1; k <= 31; k += 2) begin
            we_i       = {(k + 1 <= 31), 1'b1};
            waddr_i[0] = 5'(k);
            wdata_i[0] = 32'(k);
            waddr_i[1] = 5'(k + 1);
            wdata_i[1] = 32'(k + 1);
            step();
        end
        we_i = 2'b00;
    endtask

    initial begin
        // Reset with writes asserted
        rst_ni = 1'b0; we_i = 2'b11; waddr_i = {5'd5, 5'd5};
        wdata_i = {32'hAAAA_5555, 32'h1234_5678}; raddr_i = {5'd5, 5'd5};
        zeroize_req_i = 1'b0; dbg_req_i = 1'b1; dbg_addr_i = 5'd5;
        #1;
        chk("rst_rdata0", rdata_o[0], 32'h0);
        chk("rst_rdata1", rdata_o[1], 32'h0);
        step(); step();
        chk("rst_busy", {31'b0, zeroize_busy_o}, 32'h0);
        chk("rst_done", {31'b0, zeroize_done_o}, 32'h0);
        chk("rst_ack",  {31'b0, dbg_ack_o}, 32'h0);
        chk("rst_dbg_data", dbg_data_o, 32'h0);
        rst_ni = 1'b1; we_i = 2'b00; dbg_req_i = 1'b0;
        rd0(5'd5, 32'h0, "rst_x5_not_written");

        // Write / read, x0 write dropped
        we_i = 2'b01; waddr_i[0] = 5'd5; wdata_i[0] = 32'hDEAD_BEEF;
        step();
        we_i = 2'b00;
        rd0(5'd5, 32'hDEAD_BEEF, "wr_x5");
        we_i = 2'b01; waddr_i[0] = 5'd0; wdata_i[0] = 32'h1;
        rd0(5'd0, 32'h0, "x0_bypass_blocked");
        step();
        we_i = 2'b00;
        rd0(5'd0, 32'h0, "x0_read_zero");

        // Bypass on single port, on read port 1
        we_i = 2'b01; waddr_i[0] = 5'd6; wdata_i[0] = 32'h0000_0123; raddr_i[1] = 5'd6;
        #1;
        chk("bypass_p0_rd1", rdata_o[1], 32'h0000_0123);
        step();
        we_i = 2'b00;
        #1;
        chk("x6_stored", rdata_o[1], 32'h0000_0123);

        // Both ports write x7; port 1 wins for bypass and storage
        we_i = 2'b11; waddr_i = {5'd7, 5'd7}; wdata_i = {32'h22, 32'h11};
        rd0(5'd7, 32'h22, "bypass_prio");
        step();
        we_i = 2'b00;
        rd0(5'd7, 32'h22, "store_prio");

        // Zeroize
        fill();
        rd0(5'd31, 32'd31, "fill_x31");
        rd0(5'd5, 32'd5, "fill_x5");
        zeroize_req_i = 1'b1;
        step();
        zeroize_req_i = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            chk($sformatf("z_busy_c%0d", i), {31'b0, zeroize_busy_o}, 32'h1);
            chk($sformatf("z_done_c%0d", i), {31'b0, zeroize_done_o}, {31'b0, (i == 9)});
            if (i == 2) begin
                we_i = 2'b01; waddr_i[0] = 5'd3; wdata_i[0] = 32'h333;
                rd0(5'd3, 32'h0, "z_bypass_blocked");
            end else if (i == 4) begin
                we_i = 2'b00; dbg_req_i = 1'b1; dbg_addr_i = 5'd31;
            end else if (i == 5) begin
                dbg_req_i = 1'b0;
                chk("z_dbg_ack", {31'b0, dbg_ack_o}, 32'h1);
                chk("z_dbg_data", dbg_data_o, 32'h0);
            end else begin
                we_i = 2'b00;
            end
            step();
        end
        chk("z_busy_end", {31'b0, zeroize_busy_o}, 32'h0);
        chk("z_done_end", {31'b0, zeroize_done_o}, 32'h0);
        for (int a = 0; a < 32; a++) begin
            rd0(5'(a), 32'h0, $sformatf("z_clear_x%0d", a));
        end

        // Debug port
        we_i = 2'b11; waddr_i = {5'd10, 5'd9}; wdata_i = {32'h0000_000A, 32'h0000_CAFE};
        step();
        we_i = 2'b01; waddr_i[0] = 5'd11; wdata_i[0] = 32'h0000_000B;
        dbg_req_i = 1'b1; dbg_addr_i = 5'd9;
        step();
        we_i = 2'b01; waddr_i[0] = 5'd12; wdata_i[0] = 32'h55;
        chk("dbg_ack1", {31'b0, dbg_ack_o}, 32'h1);
        chk("dbg_data1", dbg_data_o, 32'h0000_CAFE);
        dbg_addr_i = 5'd10;
        step();
        we_i = 2'b00;
        chk("dbg_ack2", {31'b0, dbg_ack_o}, 32'h1);
        chk("dbg_data2", dbg_data_o, 32'h0000_000A);
        dbg_addr_i = 5'd11;
        step();
        chk("dbg_ack3", {31'b0, dbg_ack_o}, 32'h1);
        chk("dbg_data3", dbg_data_o, 32'h0000_000B);
        dbg_addr_i = 5'd12;
        step();
        chk("dbg_no_bypass", dbg_data_o, 32'h55);
        dbg_req_i = 1'b0;
        we_i = 2'b01; waddr_i[0] = 5'd12; wdata_i[0] = 32'h77;
        dbg_req_i = 1'b1;
        step();
        we_i = 2'b00; dbg_req_i = 1'b0;
        chk("dbg_old_value", dbg_data_o, 32'h55);
        step();
        chk("dbg_ack_idle", {31'b0, dbg_ack_o}, 32'h0);
        chk("dbg_data_idle", dbg_data_o, 32'h0);

        // Abort zeroize by reset in CLEAR cycle 3
        fill();
        zeroize_req_i = 1'b1;
        step();
        zeroize_req_i = 1'b0;
        step(); step();
        chk("abort_busy_pre", {31'b0, zeroize_busy_o}, 32'h1);
        rst_ni = 1'b0;
        rd0(5'd31, 32'h0, "abort_rdata_in_rst");
        step();
        rst_ni = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("abort_done_c%0d", i), {31'b0, zeroize_done_o}, 32'h0);
            chk($sformatf("abort_busy_c%0d", i), {31'b0, zeroize_busy_o}, 32'h0);
            step();
        end
        for (int a = 1; a < 32; a += 5) begin
            rd0(5'(a), 32'h0, $sformatf("abort_clear_x%0d", a));
        end

        // New sequence works after abort
        zeroize_req_i = 1'b1;
        step();
        zeroize_req_i = 1'b0;
        chk("restart_busy", {31'b0, zeroize_busy_o}, 32'h1);
        for (int i = 0; i < 9; i++) step();
        chk("restart_idle", {31'b0, zeroize_busy_o}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
